// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared widths, FP32 field positions, FSM states and operand unpacking for the FP adder
package fp_add_pkg;
    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MAX_SHIFT = 25;
    localparam int SH_W      = 5;
    localparam int SIGN_BIT  = 31;
    localparam int EXP_MSB   = 30;
    localparam int EXP_LSB   = 23;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, DONE} state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  eff_exp;
        logic [FRAC_W:0]   mant;
    } op_t;

    // Denormals get the hidden bit cleared and an effective exponent of 1
    function automatic op_t unpack(input logic [31:0] x);
        op_t o;
        logic [EXP_W-1:0] e;
        e         = x[EXP_MSB:EXP_LSB];
        o.sign    = x[SIGN_BIT];
        o.eff_exp = (e == '0) ? EXP_W'(1) : e;
        o.mant    = {|e, x[FRAC_W-1:0]};
        return o;
    endfunction
endpackage

// File: rtl/fp_align_shifter.sv
// fp_align_shifter: holds the smaller mantissa and right-aligns it (iterative, or barrel with FP_ALIGN_BARREL_EN)
// Ports: load_i captures m_i/sh_i, step_i shifts one bit, last_o flags the final step, m_o is the aligned mantissa
module fp_align_shifter
    import fp_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [FRAC_W:0]   m_i,
    input  logic [SH_W-1:0]   sh_i,
    output logic [FRAC_W:0]   m_o,
    output logic              last_o
);
    logic [FRAC_W:0] m_q;
`ifdef FP_ALIGN_BARREL_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) m_q <= '0;
        else if (load_i) m_q <= m_i >> sh_i;
        else if (step_i) m_q <= m_q >> 1;
    assign last_o = 1'b1;
`else
    logic [SH_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            m_q   <= m_i;
            cnt_q <= sh_i;
        end else if (step_i) begin
            m_q   <= m_q >> 1;
            cnt_q <= cnt_q - 1'b1;
        end
    assign last_o = cnt_q == SH_W'(1);
`endif
    assign m_o = m_q;
endmodule

// File: rtl/fp_align_add.sv
// fp_align_add: unpack, magnitude-order, align and add/subtract two binary32 mantissas (FP_ALIGN_BARREL_EN selects one-cycle alignment)
// Ports: a/b with in_valid/in_ready in; result_mantissa, do_subtract, big_exp, result_sign with out_valid/out_ready out
module fp_align_add
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [24:0] result_mantissa,
    output logic        do_subtract,
    output logic [7:0]  big_exp,
    output logic        result_sign,
    output logic        out_valid,
    input  logic        out_ready
);
    state_t            state_q;
    logic [31:0]       a_q, b_q;
    op_t               ua, ub, big, big_q;
    logic              b_big, dosub_q, sign_q, valid_q, last;
    logic [FRAC_W:0]   small_m_in, small_m;
    logic [EXP_W-1:0]  small_exp, d, exp_q;
    logic [SH_W-1:0]   sh;
    logic [FRAC_W+1:0] res_d, res_q;

    always_comb begin
        ua         = unpack(a_q);
        ub         = unpack(b_q);
        // Ties keep A as the big operand
        b_big      = b_q[EXP_MSB:0] > a_q[EXP_MSB:0];
        big        = b_big ? ub : ua;
        small_m_in = b_big ? ua.mant : ub.mant;
        small_exp  = b_big ? ua.eff_exp : ub.eff_exp;
        d          = big.eff_exp - small_exp;
        sh         = (d > EXP_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : d[SH_W-1:0];
        // Magnitude ordering guarantees the subtraction never goes negative
        res_d      = dosub_q ? {1'b0, big_q.mant} - {1'b0, small_m} : {1'b0, big_q.mant} + {1'b0, small_m};
    end

    fp_align_shifter u_shift (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == UNPACK),
        .step_i (state_q == ALIGN),
        .m_i    (small_m_in),
        .sh_i   (sh),
        .m_o    (small_m),
        .last_o (last)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            big_q   <= '0;
            dosub_q <= 1'b0;
            res_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
        end else
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    state_q <= UNPACK;
                end
                UNPACK: begin
                    big_q   <= big;
                    dosub_q <= a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
`ifdef FP_ALIGN_BARREL_EN
                    state_q <= ADD;
`else
                    state_q <= (sh == '0) ? ADD : ALIGN;
`endif
                end
                ALIGN: if (last) state_q <= ADD;
                ADD: begin
                    res_q   <= res_d;
                    exp_q   <= big_q.eff_exp;
                    // Exact cancellation yields +0
                    sign_q  <= big_q.sign & ~(dosub_q & (res_d == '0));
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: if (out_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

    assign in_ready        = state_q == IDLE;
    assign result_mantissa = res_q;
    assign do_subtract     = dosub_q;
    assign big_exp         = exp_q;
    assign result_sign     = sign_q;
    assign out_valid       = valid_q;
endmodule
